// File: rtl/bcd_gate_counter_pkg.sv
// Shared definitions for the gated BCD event counter: digit width, the
// largest BCD digit value, FSM state encoding and the all-nines test.
package bcd_gate_counter_pkg;

    localparam int               BCD_W      = 4;
    localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;
    localparam int               MAX_DIGITS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // True when the lowest 'digits' decades of v all hold 9.
    function automatic logic all_nines(input logic [MAX_DIGITS*BCD_W-1:0] v,
                                       input int                          digits);
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[i*BCD_W +: BCD_W] != BCD_MAX) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_gate_counter_digit.sv
// One BCD decade. Counts 0..9 on inc (unless hold), wraps 9 -> 0, and
// raises tc combinationally when it is at 9 and being incremented so the
// next decade can be chained.
module bcd_digit
    import bcd_gate_counter_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    output logic [BCD_W-1:0] value,
    output logic             tc
);

    // Decade register: async clear, then sync clear, then increment.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !hold) begin
            value <= (value == BCD_MAX) ? '0 : value + 4'd1;
        end
    end

    assign tc = (value == BCD_MAX) && inc;

endmodule

// File: rtl/bcd_gate_counter.sv
// Gated BCD event counter. Counts qualified events while gate is high,
// latches the count and overflow flag into dout/ovf when gate falls, and
// pulses valid for one cycle after each latch. SAT selects saturation at
// all-9s or wrap to zero on overflow.
module bcd_gate_counter
    import bcd_gate_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit SAT    = 1'b1
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    gate,
    input  logic                    sync_clr,
    output logic [BCD_W*DIGITS-1:0] dout,
    output logic                    co,
    output logic                    ovf,
    output logic                    valid
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    gate_q;
    logic                    rise;
    logic                    fall;
    logic                    count_win;
    logic                    latch_win;
    logic                    clr_live;
    logic                    count_en;
    logic                    hold;
    logic                    wrap_evt;
    logic                    co_d;
    logic                    live_ovf;
    logic [BCD_W*DIGITS-1:0] live;
    logic [MAX_DIGITS*BCD_W-1:0] live_pad;
    logic [DIGITS-1:0]       inc_chain;
    logic [DIGITS-1:0]       tc;

    // Delayed gate for edge detection.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
        end
    end

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    // FSM state register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: open window on rise, close and latch on fall.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        count_win = 1'b0;
        latch_win = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                count_win = gate;
                if (fall) begin
                    state_d   = IDLE;
                    latch_win = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new window or an explicit clear restarts the live count; either
    // one swallows the en of that cycle.
    assign clr_live = rise | sync_clr;
    assign count_en = count_win & en & ~clr_live;

    // Widen the live count so the package helper can examine it.
    always_comb begin
        live_pad                   = '0;
        live_pad[BCD_W*DIGITS-1:0] = live;
    end

    // In saturating mode, freeze every decade once all of them read 9.
    assign hold = SAT && all_nines(live_pad, DIGITS);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            if (g == 0) begin : g_first
                assign inc_chain[g] = count_en;
            end else begin : g_rest
                assign inc_chain[g] = tc[g-1];
            end

            bcd_digit u_digit (
                .clk   (clk),
                .clear (clear),
                .clr   (clr_live),
                .inc   (inc_chain[g]),
                .hold  (hold),
                .value (live[g*BCD_W +: BCD_W]),
                .tc    (tc[g])
            );
        end
    endgenerate

    // An increment attempted at all-9s is an overflow event. Saturating
    // mode reports only the first one per window; wrap mode reports each.
    assign wrap_evt = tc[DIGITS-1];
    assign co_d     = wrap_evt & (~SAT | ~live_ovf);

    // Live overflow flag, sticky until the window restarts or is cleared.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            live_ovf <= 1'b0;
        end else if (clr_live) begin
            live_ovf <= 1'b0;
        end else if (wrap_evt) begin
            live_ovf <= 1'b1;
        end
    end

    // Registered carry-out pulse.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            co <= 1'b0;
        end else begin
            co <= co_d;
        end
    end

    // Result latch: capture the pre-clear live count on window close.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            dout  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= latch_win;
            if (latch_win) begin
                dout <= live;
                ovf  <= live_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bcd_gate_counter.sv
// Self-checking bench: three counter instances (4 digits saturating,
// 2 digits saturating, 2 digits wrapping) share one stimulus stream and are
// compared every cycle against an integer-arithmetic reference model.
module tb_bcd_gate_counter;

    logic        clk = 1'b0;
    logic        clear;
    logic        en;
    logic        gate;
    logic        sync_clr;

    logic [15:0] dout4;
    logic [7:0]  dout2s;
    logic [7:0]  dout2w;
    logic        co4, co2s, co2w;
    logic        ovf4, ovf2s, ovf2w;
    logic        valid4, valid2s, valid2w;

    bcd_gate_counter #(.DIGITS(4), .SAT(1'b1)) dut4 (
        .clk(clk), .clear(clear), .en(en), .gate(gate), .sync_clr(sync_clr),
        .dout(dout4), .co(co4), .ovf(ovf4), .valid(valid4)
    );

    bcd_gate_counter #(.DIGITS(2), .SAT(1'b1)) dut2s (
        .clk(clk), .clear(clear), .en(en), .gate(gate), .sync_clr(sync_clr),
        .dout(dout2s), .co(co2s), .ovf(ovf2s), .valid(valid2s)
    );

    bcd_gate_counter #(.DIGITS(2), .SAT(1'b0)) dut2w (
        .clk(clk), .clear(clear), .en(en), .gate(gate), .sync_clr(sync_clr),
        .dout(dout2w), .co(co2w), .ovf(ovf2w), .valid(valid2w)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: live counts as plain integers, index 0/1/2 = dut4/dut2s/dut2w.
    int m_max[3]  = '{9999, 99, 99};
    bit m_sat[3]  = '{1'b1, 1'b1, 1'b0};
    int m_live[3];
    bit m_lovf[3];
    int m_dout[3];
    bit m_ovf[3];
    bit m_valid[3];
    bit m_co[3];
    bit m_gprev;

    int c4, c2s, c2w;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_live[d]  = 0;
            m_lovf[d]  = 1'b0;
            m_dout[d]  = 0;
            m_ovf[d]   = 1'b0;
            m_valid[d] = 1'b0;
            m_co[d]    = 1'b0;
        end
        m_gprev = 1'b0;
    endtask

    // One clock edge of the model, using the inputs the DUTs just sampled.
    task automatic model_edge();
        bit r, f;
        r = gate && !m_gprev;
        f = !gate && m_gprev;
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = f;
            m_co[d]    = 1'b0;
            if (f) begin
                m_dout[d] = m_live[d];
                m_ovf[d]  = m_lovf[d];
            end
            if (r || sync_clr) begin
                m_live[d] = 0;
                m_lovf[d] = 1'b0;
            end else if (m_gprev && gate && en) begin
                if (m_live[d] == m_max[d]) begin
                    m_co[d]   = !m_sat[d] || !m_lovf[d];
                    m_lovf[d] = 1'b1;
                    m_live[d] = m_sat[d] ? m_max[d] : 0;
                end else begin
                    m_live[d] = m_live[d] + 1;
                end
            end
        end
        m_gprev = gate;
    endtask

    task automatic compare();
        check("dout4",   32'(dout4),   to_bcd(m_dout[0]));
        check("ovf4",    32'(ovf4),    32'(m_ovf[0]));
        check("valid4",  32'(valid4),  32'(m_valid[0]));
        check("co4",     32'(co4),     32'(m_co[0]));
        check("dout2s",  32'(dout2s),  to_bcd(m_dout[1]));
        check("ovf2s",   32'(ovf2s),   32'(m_ovf[1]));
        check("valid2s", 32'(valid2s), 32'(m_valid[1]));
        check("co2s",    32'(co2s),    32'(m_co[1]));
        check("dout2w",  32'(dout2w),  to_bcd(m_dout[2]));
        check("ovf2w",   32'(ovf2w),   32'(m_ovf[2]));
        check("valid2w", 32'(valid2w), 32'(m_valid[2]));
        check("co2w",    32'(co2w),    32'(m_co[2]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (co4)  c4++;
        if (co2s) c2s++;
        if (co2w) c2w++;
    endtask

    // Rise cycle, n counted cycles, fall cycle (optionally with sync_clr), one idle cycle.
    task automatic window(input int n, input bit clr_at_fall);
        c4 = 0; c2s = 0; c2w = 0;
        gate = 1'b1; en = 1'b1; sync_clr = 1'b0;
        step();
        repeat (n) step();
        gate = 1'b0; sync_clr = clr_at_fall;
        step();
        sync_clr = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b1; en = 1'b0; gate = 1'b0; sync_clr = 1'b0;
        model_reset();
        #13;
        compare();
        clear = 1'b0;

        // en while idle must do nothing.
        en = 1'b1;
        repeat (4) step();

        // Short window of 10 counted events.
        window(10, 1'b0);
        check("short_dout4", 32'(dout4), 32'h0010);

        // 1234 events: exact BCD result, no overflow on the 4-digit unit.
        window(1234, 1'b0);
        check("w1234_dout4", 32'(dout4), 32'h1234);
        check("w1234_ovf4",  32'(ovf4),  32'h0);
        check("w1234_co4",   32'(c4),    32'd0);

        // 105 events: 2-digit saturating vs wrapping behaviour.
        window(105, 1'b0);
        check("w105_dout2s", 32'(dout2s), 32'h99);
        check("w105_ovf2s",  32'(ovf2s),  32'h1);
        check("w105_co2s",   32'(c2s),    32'd1);
        check("w105_dout2w", 32'(dout2w), 32'h05);
        check("w105_ovf2w",  32'(ovf2w),  32'h1);
        check("w105_co2w",   32'(c2w),    32'd1);

        // sync_clr after 50 counts, 7 more before the window closes.
        gate = 1'b1; en = 1'b1;
        step();
        repeat (50) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        repeat (7) step();
        gate = 1'b0;
        step();
        step();
        check("sclr_dout4", 32'(dout4), 32'h0007);
        check("sclr_ovf4",  32'(ovf4),  32'h0);

        // sync_clr coincident with fall still latches the pre-clear count.
        window(20, 1'b1);
        check("sclr_fall_dout4", 32'(dout4), 32'h0020);

        // Randomised gate/en/sync_clr traffic.
        gate = 1'b0; en = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            en       = ($urandom_range(0, 3) != 0);
            sync_clr = ($urandom_range(0, 49) == 0);
            step();
        end
        gate = 1'b0; en = 1'b0; sync_clr = 1'b0;
        repeat (3) step();

        // Asynchronous clear mid-window, then restart with gate still high.
        gate = 1'b1; en = 1'b1;
        step();
        repeat (300) step();
        #2;
        clear = 1'b1;
        model_reset();
        #1;
        check("clr_dout4",  32'(dout4),  32'h0);
        check("clr_valid4", 32'(valid4), 32'h0);
        check("clr_ovf4",   32'(ovf4),   32'h0);
        check("clr_co4",    32'(co4),    32'h0);
        compare();
        #1;
        clear = 1'b0;
        step();
        repeat (5) step();
        gate = 1'b0;
        step();
        check("restart_valid4", 32'(valid4), 32'h1);
        step();
        check("restart_dout4", 32'(dout4), 32'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_gate_counter.md
BCD_GATE_COUNTER -- requirements
Module: bcd_gate_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD decades, legal range 1..8.
REQ-002 Parameter SAT, default 1: 1 = saturate at all-9s on overflow, 0 = wrap to zero on overflow.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 clear  input  1: asynchronous, active-high reset.
REQ-005 en  input  1: count-event qualifier; one increment per clk edge while high and the block is counting.
REQ-006 gate  input  1: measurement window, synchronous to clk; the block counts while gate is high.
REQ-007 sync_clr  input  1: synchronous clear of the live count and live overflow flag.
REQ-008 dout  output  4*DIGITS: latched BCD result; digit 0 (least significant) occupies bits [3:0].
REQ-009 co  output  1: registered one-cycle pulse when the live count passes all-9s.
REQ-010 ovf  output  1: latched overflow flag for the last completed window.
REQ-011 valid  output  1: one-cycle pulse when dout/ovf have been updated.

Function
REQ-012 Registered copy gate_q of gate: rise = gate&~gate_q; fall = ~gate&gate_q.
REQ-013 FSM states: IDLE, COUNT.
- IDLE->COUNT on rise.
- COUNT->IDLE on fall.
- No other transitions.
REQ-014 On rise: live count <- 0, live_ovf <- 0; en is ignored in that cycle.
REQ-015 In COUNT with gate=1 and en=1: live count increments by 1 in BCD.
- Digit k increments when en and digits 0..k-1 all equal 9.
- A digit at 9 that increments becomes 0.
- Digit values outside 0..9 never occur.
REQ-016 Increment from all-9s:
- co=1 in the following cycle.
- live_ovf <- 1.
- SAT=1: count holds at all-9s; co pulses only on the first such attempt in a window.
- SAT=0: count becomes 0; co pulses on every wrap.
REQ-017 On fall: dout <- live count, ovf <- live_ovf, valid=1 in the following cycle only; the live count is not cleared.
REQ-018 dout and ovf change only on fall or reset; sync_clr does not affect them.
REQ-019 sync_clr=1: live count <- 0, live_ovf <- 0, en ignored that cycle; FSM state unchanged.
- sync_clr has priority over counting.
- sync_clr coincident with rise has the same effect as rise alone.
REQ-020 sync_clr coincident with fall: the pre-clear live count is latched into dout, then the live count is cleared.
REQ-021 en while IDLE: no effect.
REQ-022 co and valid are never asserted for more than one consecutive cycle from a single event.

Reset
REQ-023 clear=1 asynchronously forces the following to zero: state=IDLE, gate_q=0, live count=0, live_ovf=0, dout=0, co=0, ovf=0, valid=0.
REQ-024 Reset mid-window abandons the window: no valid pulse and dout=0.
- If gate is high when clear deasserts, the first clock is treated as rise and counting starts.

Structure
REQ-025 Shared package holds:
- BCD_W=4 and BCD_MAX=4'd9.
- The FSM state enumeration {IDLE, COUNT}.
- A function for the all-9s test.
REQ-026 One sub-module, bcd_digit:
- Ports: clk, clear, clr (synchronous), inc, hold.
- Outputs: 4-bit value, and tc (value==9 & inc).
- Instantiated DIGITS times in a generate loop, with tc chained into the next digit's inc.
REQ-027 The top level contains only gate-edge detection, the FSM, saturation/overflow control, and the output latch registers.

Verification
REQ-028 DIGITS=4: gate high for 10 cycles with en=1 after rise -> valid pulse one cycle after fall, dout=16'h0009 or 16'h0010 as counted; bench checks the exact count against a scoreboard.
REQ-029 DIGITS=4: gate high with en=1 for exactly 1234 counted cycles -> dout=16'h1234, ovf=0, co never asserted.
REQ-030 DIGITS=2, SAT=1: 105 counted cycles -> dout=8'h99, ovf=1, exactly one co pulse.
REQ-031 DIGITS=2, SAT=0: 105 counted cycles -> dout=8'h05, ovf=1, exactly one co pulse at the 100th increment.
REQ-032 sync_clr pulsed after 50 counts, then 7 more counts before fall -> dout=16'h0007 and ovf=0; a second sync_clr coincident with fall still latches the pre-clear value.
REQ-033 clear asserted mid-window after 300 counts -> all outputs 0 immediately (asynchronously); with gate held high, counting restarts from 0 after clear deasserts.
